div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle integer divide unit for the execute stage; computes the RV32M DIV, DIVU, REM and REMU operations.
- The combinational ALU does not implement these. The decode/execute control steers divide operations here instead.
- Uses the ALU's 5-bit operation encoding and the same operand buses.
- Its result feeds the execute-stage writeback mux alongside the ALU result. The pipeline stalls while busy is high.

Parameters:
- WIDTH, 32: operand/result width. Only 32 is supported.
- CNT_W, 6: iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- AluControl  input  5  operation: 01111 DIV, 10000 DIVU, 10001 REM, 10010 REMU.
- a  input  32  dividend.
- b  input  32  divisor.
- kill  input  1  synchronous abort (pipeline flush).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  quotient or remainder; held until next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. An operation in flight is discarded and no done is produced.
- States are IDLE, CALC and FIX.
- IDLE -> CALC:
  - Condition: start=1 and AluControl is one of the four divide codes.
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Latch quotient sign = a[31]^b[31] (signed only) and remainder sign = a[31] (signed only).
  - Latch op, a, and the flags div-by-zero (b==0) and overflow (DIV/REM with a==0x80000000, b==0xFFFFFFFF).
  - Clear the 33-bit partial remainder and set count=0.
- start with any other AluControl code is ignored; state stays IDLE.
- start while not in IDLE is ignored. Operands are not re-latched and there is no queueing.
- CALC: one restoring radix-2 step per cycle, MSB first.
  - Shift the remainder left, bringing in the next dividend bit.
  - Trial subtract the divisor. If it does not go negative, keep the difference and set the quotient bit to 1; otherwise set it to 0.
  - After 32 steps (count==31 at that edge), go to FIX.
- FIX (one cycle):
  - Select quotient or remainder.
  - Apply two's-complement negation for signed results whose sign is set.
  - Apply the special-case overrides.
  - Write result, pulse done for the next cycle, return to IDLE.
- Special cases (RISC-V semantics). Latency is unchanged; there is no early exit.
  - b==0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - Overflow: DIV returns 0x80000000; REM returns 0.
- Timing: start sampled at edge N.
  - busy=1 from N+1 through N+33.
  - done=1 for exactly cycle N+34 (registered), with result valid in that same cycle.
  - busy=0 while done=1.
  - A new start may be accepted at edge N+34, back-to-back.
- done is never asserted in the same cycle as busy=1.
- kill:
  - In CALC or FIX: go to IDLE next edge with busy=0. No done; result keeps its previous value.
  - In IDLE: no effect.
  - kill has priority over a simultaneous start, which is not accepted.
- result changes only on the FIX->IDLE edge or on reset.

Test Plan:
- DIV a=100, b=7 -> done at N+34, result=14; then REM with the same operands -> 2; busy high for 33 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF; REMU -> 1.
- Divide by zero, a=0x12345678, b=0:
  - DIV and DIVU -> 0xFFFFFFFF.
  - REM and REMU -> 0x12345678.
  - Latency stays 34 in all four cases.
- Overflow a=0x80000000, b=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- start pulsed at N+5 during busy with different operands -> ignored, original result returned. Back-to-back start at N+34 accepted, done at N+68.
- kill at N+10 -> busy=0 at N+11, no done, result unchanged.
  - rst_n low mid-CALC -> immediately busy=0, done=0, result=0.
  - start with AluControl=00010 -> no busy, no done.

Source files
------------

// File: rtl/div_if.sv
// Divide unit handshake and operand bundle shared by execute control and the divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       AluControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, AluControl, a, b, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, AluControl, a, b, kill,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), restoring radix-2, one bit per cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start with a divide opcode; result held
// S_CALC | 32 restoring steps, MSB first, count 0..31
// S_FIX  | sign fix-up and special-case override; result written on exit
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic  clk,
  input  logic  rst_n,
  div_if.slave  bus
);

  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_DIVU = 5'b10000;
  localparam logic [4:0] OP_REM  = 5'b10001;
  localparam logic [4:0] OP_REMU = 5'b10010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a;
  logic             r_is_rem;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;
  logic             r_ovf;
  logic [WIDTH-1:0] r_result;
  logic             r_done;

  logic             w_is_div;
  logic             w_is_signed;
  logic             w_is_rem;
  logic             w_accept;
  logic             w_last;
  logic             w_fix_wr;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  // Decode the ALU operation code into divider controls.
  always_comb begin
    w_is_div    = 1'b0;
    w_is_signed = 1'b0;
    w_is_rem    = 1'b0;
    case (bus.AluControl)
      OP_DIV:  begin w_is_div = 1'b1; w_is_signed = 1'b1; end
      OP_DIVU: begin w_is_div = 1'b1; end
      OP_REM:  begin w_is_div = 1'b1; w_is_signed = 1'b1; w_is_rem = 1'b1; end
      OP_REMU: begin w_is_div = 1'b1; w_is_rem = 1'b1; end
      default: ;
    endcase
  end

  assign w_abs_a = (w_is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign w_abs_b = (w_is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

  // Trial subtract; the extra top bit of the difference is the borrow.
  assign w_diff = {1'b0, r_rem, r_quo[WIDTH-1]} - {2'b00, r_div};
  assign w_ge   = ~w_diff[WIDTH+1];
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; kill wins over both progress and a simultaneous start.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fix_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && w_is_div && !bus.kill) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.kill)    w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
        w_fix_wr    = !bus.kill;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Final result selection: sign correction then RISC-V special cases.
  always_comb begin
    w_res = '0;
    if (r_dz) begin
      w_res = r_is_rem ? r_a : '1;
    end else if (r_ovf) begin
      w_res = r_is_rem ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end else if (r_is_rem) begin
      w_res = r_rneg ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
    end else begin
      w_res = r_qneg ? (~r_quo + 1'b1) : r_quo;
    end
  end

  // Operand capture, iteration datapath, result and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_a      <= '0;
      r_is_rem <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_rem    <= '0;
        r_quo    <= w_abs_a;
        r_div    <= w_abs_b;
        r_a      <= bus.a;
        r_is_rem <= w_is_rem;
        r_qneg   <= w_is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        r_rneg   <= w_is_signed & bus.a[WIDTH-1];
        r_dz     <= (bus.b == '0);
        r_ovf    <= w_is_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
      end else if (r_state == S_CALC && !bus.kill) begin
        r_rem <= w_ge ? w_diff[WIDTH:0] : {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fix_wr) r_result <= w_res;
      r_done <= w_fix_wr;
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, start/kill/reset behaviour.
module tb_div_unit;

  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_DIVU = 5'b10000;
  localparam logic [4:0] OP_REM  = 5'b10001;
  localparam logic [4:0] OP_REMU = 5'b10010;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   t_start = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request, let edge N sample it, then drop start.
  task automatic issue(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
    bus.AluControl = op;
    bus.a          = av;
    bus.b          = bv;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t_start   = cyc;
  endtask

  // Wait for done; cycle index k means the cycle after edge N+k-1.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int lat  = -1;
    int gaps = 0;
    while ((cyc - t_start) < 45 && lat < 0) begin
      @(negedge clk);
      if (bus.done) begin
        lat = cyc - t_start + 1;
        check_val({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      end else if (!bus.busy) begin
        gaps++;
      end
    end
    check_val({tag, "_latency"}, 32'(lat), 32'd34);
    check_val({tag, "_result"}, bus.result, exp);
    check_val({tag, "_busy_gaps"}, 32'(gaps), 32'd0);
  endtask

  // Watch a fixed number of cycles and count busy/done cycles.
  task automatic watch(input int ncyc, output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
      if (bus.done) ndone++;
    end
  endtask

  initial begin
    int nb;
    int nd;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.kill       = 1'b0;
    bus.AluControl = 5'd0;
    bus.a          = '0;
    bus.b          = '0;
    #12;
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(OP_DIV, 32'd100, 32'd7);
    wait_done("div_100_7", 32'd14);
    @(negedge clk);
    check_val("done_one_cycle", {31'd0, bus.done}, 32'd0);
    issue(OP_REM, 32'd100, 32'd7);
    wait_done("rem_100_7", 32'd2);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 32'hFFFF_FFFD);
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2);
    wait_done("rem_m7_2", 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd2);
    wait_done("divu_max_2", 32'h7FFF_FFFF);
    issue(OP_REMU, 32'hFFFF_FFFF, 32'd2);
    wait_done("remu_max_2", 32'd1);

    issue(OP_DIV, 32'h1234_5678, 32'd0);
    wait_done("div_dz", 32'hFFFF_FFFF);
    issue(OP_DIVU, 32'h1234_5678, 32'd0);
    wait_done("divu_dz", 32'hFFFF_FFFF);
    issue(OP_REM, 32'h1234_5678, 32'd0);
    wait_done("rem_dz", 32'h1234_5678);
    issue(OP_REMU, 32'h1234_5678, 32'd0);
    wait_done("remu_dz", 32'h1234_5678);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'h8000_0000);
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("rem_ovf", 32'd0);

    // start pulsed at edge N+5 with other operands must be ignored
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    bus.AluControl = OP_REMU;
    bus.a          = 32'd50;
    bus.b          = 32'd3;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("busy_start_ignored", 32'd14);
    issue(OP_DIVU, 32'd1000, 32'd10);
    wait_done("back_to_back", 32'd100);

    // kill sampled at edge N+10
    issue(OP_DIVU, 32'd9, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check_val("kill_busy", {31'd0, bus.busy}, 32'd0);
    watch(40, nb, nd);
    check_val("kill_no_done", 32'(nd), 32'd0);
    check_val("kill_result_kept", bus.result, 32'd100);

    // kill and start together in IDLE: start not accepted
    bus.kill = 1'b1;
    issue(OP_DIV, 32'd100, 32'd7);
    bus.kill = 1'b0;
    watch(5, nb, nd);
    check_val("kill_start_busy", 32'(nb), 32'd0);

    // unsupported opcode ignored
    issue(5'b00010, 32'd100, 32'd7);
    watch(40, nb, nd);
    check_val("badop_busy", 32'(nb), 32'd0);
    check_val("badop_done", 32'(nd), 32'd0);

    // asynchronous reset in the middle of CALC
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("midrst_done", {31'd0, bus.done}, 32'd0);
    check_val("midrst_result", bus.result, 32'd0);
    #3;
    rst_n = 1'b1;
    watch(40, nb, nd);
    check_val("midrst_no_done", 32'(nd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
